// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// This is the fetch stage of a 5-stage pipeline. It holds the program counter,
// a loader-writable instruction memory and the IF/ID pipeline register.
//
// Parameters
//   NB_DATA      instruction, PC and address width (default 32)
//   IMEM_DEPTH   instruction-memory depth in words (default 256)
//
// Ports
//   clk            single clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_enable       run enable (debug single-step); 0 freezes PC and IF/ID
//   i_stall        load-use stall; holds PC and IF/ID
//   i_flush        squashes IF/ID to a NOP bubble
//   i_jump         jump redirect, target i_jump_addr (highest priority)
//   i_branch       taken-branch redirect, target i_branch_addr
//   i_load_en      loader write strobe; holds PC and bubbles IF/ID
//   i_load_addr    loader word address
//   i_load_data    loader instruction word
//   o_instruction  IF/ID instruction
//   o_pcounter4    IF/ID PC+4
//   o_valid        IF/ID holds a real fetched instruction
//   o_halted       fetch is halted
//   o_dbg_state    FSM state (0 = RUN, 1 = HALTED)
//
// Handshake: there is no valid/ready flow control here. IF/ID moves forward on
// every edge where i_enable=1, i_load_en=0, i_stall=0 and the FSM is in RUN.
// o_valid qualifies o_instruction/o_pcounter4 for decode.
//
// Build option
//   IF_HALT_DETECT_EN  When this is defined, fetching the all-ones word halts
//                      fetch until reset. When it is undefined, that word is
//                      ordinary, o_halted is 0 and HALTED is never entered.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter  int NB_DATA      = 32,
    parameter  int IMEM_DEPTH   = 256,
    localparam int NB_IMEM_ADDR = $clog2(IMEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_jump,
    input  logic [NB_DATA-1:0]      i_jump_addr,
    input  logic                    i_branch,
    input  logic [NB_DATA-1:0]      i_branch_addr,
    input  logic                    i_load_en,
    input  logic [NB_IMEM_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0]      i_load_data,
    output logic [NB_DATA-1:0]      o_instruction,
    output logic [NB_DATA-1:0]      o_pcounter4,
    output logic                    o_valid,
    output logic                    o_halted,
    output logic                    o_dbg_state
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_DATA-1:0]      pc_q, pc_d;
    logic [NB_DATA-1:0]      instr_q, instr_d;
    logic [NB_DATA-1:0]      pc4_q, pc4_d;
    logic                    valid_q, valid_d;

    // Reset does not clear the instruction memory, so a program loaded
    // while reset is held is still there after reset is released.
    logic [NB_DATA-1:0]      imem_q [IMEM_DEPTH];

    logic [NB_IMEM_ADDR-1:0] fetch_idx;
    logic [NB_DATA-1:0]      fetch_word;
    logic [NB_DATA-1:0]      pc_plus4;
    logic                    halted;

    // Byte PC to word index. PC[1:0] is dropped. The index is truncated to
    // NB_IMEM_ADDR bits, so addresses past the end of memory wrap around.
    assign fetch_idx  = pc_q[NB_IMEM_ADDR+1:2];
    assign fetch_word = imem_q[fetch_idx];
    assign pc_plus4   = pc_q + NB_DATA'(4);

`ifdef IF_HALT_DETECT_EN
    assign halted = (state_q == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

    // Loader write port. It is synchronous, so a fetch on the next edge
    // already reads the new word through the combinational read path.
    always_ff @(posedge clk) begin
        if (i_load_en) begin
            imem_q[i_load_addr] <= i_load_data;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        state_d = state_q;

        if (i_load_en) begin
            // A loader write has priority over everything else. PC holds and
            // decode sees a bubble.
            instr_d = '0;
            valid_d = 1'b0;
        end else if (i_enable) begin
            // A redirect loads PC even during a stall, so the target is not
            // lost while IF/ID is held. In HALTED, PC is frozen.
            if (!halted) begin
                if (i_jump) begin
                    pc_d = i_jump_addr;
                end else if (i_branch) begin
                    pc_d = i_branch_addr;
                end else if (!i_stall) begin
                    pc_d = pc_plus4;
                end
            end

            // A flush bubble leaves PC+4 unchanged. HALTED also bubbles,
            // whatever i_stall is.
            if (i_flush || halted) begin
                instr_d = '0;
                valid_d = 1'b0;
            end else if (!i_stall) begin
                instr_d = fetch_word;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
`ifdef IF_HALT_DETECT_EN
                // The halt is flagged on the same edge that latches the
                // all-ones word into IF/ID.
                if (fetch_word == '1) begin
                    state_d = ST_HALTED;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_pcounter4   = pc4_q;
    assign o_valid       = valid_q;
    assign o_halted      = halted;
    assign o_dbg_state   = state_q;

endmodule
